// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared encodings and constants for the PS/2 keyboard receiver.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    localparam int FRAME_DATA_BITS = 8;

    // PS/2 uses odd parity: data plus parity bit must hold an odd count of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_sync_filter
// Brief    : 2-FF synchroniser, run-length glitch filter and falling-edge
//            detector for one PS/2 line.
// Revision : 1.0
// ============================================================================
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_level <= 1'b1;
            r_prev  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
            r_prev <= r_level;
            // The level only flips once the new value has been seen FILTER_LEN times in a row.
            if (r_sync != r_level) begin
                if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
                    r_level <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign fall  = r_prev & ~r_level;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_rx
// Brief    : PS/2 device-to-host deframer with make/break/extended decode.
// Revision : 1.0
// ============================================================================
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_released,
    output logic       ext,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic            w_clk_level;
    logic            w_strobe;
    logic            r_data_meta;
    logic            r_data_sync;
    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_break_pending;
    logic            r_ext_pending;
    logic [7:0]      r_key_code;
    logic            r_ext;
    logic            r_key_valid;
    logic            r_key_released;
    logic            r_parity_err;
    logic            r_frame_err;

    logic w_timeout;
    logic w_frame_done;
    logic w_stop_bad;
    logic w_par_bad;
    logic w_byte_ok;
    logic w_is_prefix;
    logic w_valid_n;
    logic w_released_n;
    logic w_parity_err_n;
    logic w_frame_err_n;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk   (clk),
        .clear (clear),
        .raw   (ps2_clk),
        .level (w_clk_level),
        .fall  (w_strobe)
    );

    // Data is only sampled on filtered clock strobes, so a plain synchroniser is enough.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_data_meta <= ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A strobe in the same cycle as the terminal count suppresses the timeout.
    assign w_timeout = (r_state != ST_IDLE) && !w_strobe &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_strobe && !r_data_sync) w_next = ST_DATA;
            ST_DATA:   if (w_strobe && r_bit_cnt == 3'(FRAME_DATA_BITS - 1)) w_next = ST_PARITY;
            ST_PARITY: if (w_strobe) w_next = ST_STOP;
            ST_STOP:   if (w_strobe) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (w_timeout) w_next = ST_IDLE;
    end

    always_comb begin
        w_frame_done   = (r_state == ST_STOP) && w_strobe;
        w_stop_bad     = w_frame_done && !r_data_sync;
        w_par_bad      = w_frame_done && r_data_sync && !parity_ok(r_shift, r_parity);
        w_byte_ok      = w_frame_done && r_data_sync && parity_ok(r_shift, r_parity);
        w_is_prefix    = (r_shift == BREAK_CODE) || (r_shift == EXT_CODE);
        w_valid_n      = w_byte_ok && !w_is_prefix && !r_break_pending;
        w_released_n   = w_byte_ok && !w_is_prefix && r_break_pending;
        w_parity_err_n = w_par_bad;
        w_frame_err_n  = ((r_state == ST_IDLE) && w_strobe && r_data_sync) ||
                         w_stop_bad || w_timeout;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_parity        <= 1'b0;
            r_to_cnt        <= '0;
            r_break_pending <= 1'b0;
            r_ext_pending   <= 1'b0;
            r_key_code      <= 8'h00;
            r_ext           <= 1'b0;
            r_key_valid     <= 1'b0;
            r_key_released  <= 1'b0;
            r_parity_err    <= 1'b0;
            r_frame_err     <= 1'b0;
        end else begin
            r_key_valid    <= w_valid_n;
            r_key_released <= w_released_n;
            r_parity_err   <= w_parity_err_n;
            r_frame_err    <= w_frame_err_n;

            if (r_state == ST_IDLE || w_strobe || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_strobe) begin
                case (r_state)
                    ST_IDLE:   r_bit_cnt <= '0;
                    ST_DATA: begin
                        r_shift   <= {r_data_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    ST_PARITY: r_parity <= r_data_sync;
                    default:   ;
                endcase
            end

            if (w_stop_bad || w_par_bad) begin
                r_break_pending <= 1'b0;
                r_ext_pending   <= 1'b0;
            end

            if (w_byte_ok) begin
                if (r_shift == BREAK_CODE) begin
                    r_break_pending <= 1'b1;
                end else if (r_shift == EXT_CODE) begin
                    r_ext_pending <= 1'b1;
                end else begin
                    r_break_pending <= 1'b0;
                    r_ext_pending   <= 1'b0;
                    r_ext           <= r_ext_pending;
                    if (!r_break_pending) begin
                        r_key_code <= r_shift;
                    end else if (r_shift == r_key_code) begin
                        r_key_code <= 8'h00;
                    end
                end
            end
        end
    end

    assign key_code     = r_key_code;
    assign ext          = r_ext;
    assign key_valid    = r_key_valid;
    assign key_released = r_key_released;
    assign parity_err   = r_parity_err;
    assign frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keyboard_rx
// Brief    : Scoreboard bench for ps2_keyboard_rx driving bit-level PS/2 frames.
// Revision : 1.0
// ============================================================================
module tb_ps2_keyboard_rx;

    localparam int HALF = 25;
    localparam int GAP  = 100;

    localparam int EV_VALID = 0;
    localparam int EV_REL   = 1;
    localparam int EV_PAR   = 2;
    localparam int EV_FRAME = 3;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       ext;
    } ev_t;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_released;
    logic       ext;
    logic       parity_err;
    logic       frame_err;

    ev_t        sb[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         t_fall = 0;
    int         t_ferr = 0;
    int         n_ferr = 0;

    logic [7:0] m_key = 8'h00;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_extp = 1'b0;

    ps2_keyboard_rx dut (
        .clk          (clk),
        .clear        (clear),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_released (key_released),
        .ext          (ext),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic push(input int kind);
        ev_t e;
        e.kind = kind;
        e.code = m_key;
        e.ext  = m_ext;
        sb.push_back(e);
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic par_ok, input logic stop_ok);
        if (!stop_ok || !par_ok) begin
            push(stop_ok ? EV_PAR : EV_FRAME);
            m_brk  = 1'b0;
            m_extp = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_extp = 1'b1;
        end else begin
            m_ext = m_extp;
            if (m_brk) begin
                if (b == m_key) m_key = 8'h00;
                push(EV_REL);
            end else begin
                m_key = b;
                push(EV_VALID);
            end
            m_brk  = 1'b0;
            m_extp = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic par_flip, input logic stop_val,
                             input int nbits, input logic glitch);
        logic [10:0] bits;
        bits = {stop_val, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = bits[i];
            if (glitch && i == 4) begin
                repeat (8) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (5) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF - 13) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b0;
            t_fall  = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input logic par_flip = 1'b0,
                         input logic stop_val = 1'b1, input logic glitch = 1'b0);
        expect_byte(b, !par_flip, stop_val);
        send_bits(b, par_flip, stop_val, 11, glitch);
    endtask

    always @(negedge clk) begin
        int  n;
        int  kind;
        ev_t e;
        if (!clear && (key_valid || key_released || parity_err || frame_err)) begin
            n = int'(key_valid) + int'(key_released) + int'(parity_err) + int'(frame_err);
            check("pulse_onehot", n, 1);
            kind = key_valid ? EV_VALID : key_released ? EV_REL : parity_err ? EV_PAR : EV_FRAME;
            if (kind == EV_FRAME) begin
                t_ferr = cyc;
                n_ferr++;
            end
            if (sb.size() == 0) begin
                check("unexpected_event", kind, -1);
            end else begin
                e = sb.pop_front();
                check("event_kind", kind, e.kind);
                check("event_key_code", int'(key_code), int'(e.code));
                check("event_ext", int'(ext), int'(e.ext));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_key_code"}, int'(key_code), 0);
        check({tag, "_ext"}, int'(ext), 0);
        check({tag, "_pulses"}, int'({key_valid, key_released, parity_err, frame_err}), 0);
    endtask

    initial begin
        int f0;
        int lat;
        repeat (5) @(negedge clk);
        check_reset_values("reset");
        clear = 1'b0;
        repeat (20) @(negedge clk);

        // Sub-filter glitch while idle: a real strobe here would raise frame_err.
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (GAP) @(negedge clk);

        frame(8'h1C);
        frame(8'hF0); frame(8'h1C);
        frame(8'hF0); frame(8'h23);
        frame(8'hE0); frame(8'h75);
        frame(8'h29);
        frame(8'h1C, 1'b1);
        frame(8'h24);
        frame(8'hE0); frame(8'h1C, 1'b1); frame(8'h6B);

        // Timeout after five bits; the break prefix survives it.
        frame(8'hF0);
        push(EV_FRAME);
        f0 = n_ferr;
        send_bits(8'h6B, 1'b0, 1'b1, 5, 1'b0);
        repeat (60000) @(negedge clk);
        check("timeout_count", n_ferr - f0, 1);
        lat = t_ferr - t_fall;
        check("timeout_latency_ok", int'(lat >= 50000 && lat <= 50040), 1);
        frame(8'h6B);

        frame(8'h5A, 1'b0, 1'b1, 1'b1);
        frame(8'h33, 1'b0, 1'b0);

        push(EV_FRAME);
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (GAP) @(negedge clk);

        frame(8'h4D);
        frame(8'hE0);
        send_bits(8'h12, 1'b0, 1'b1, 4, 1'b0);
        clear = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("mid_clear");
        clear  = 1'b0;
        m_key  = 8'h00;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_extp = 1'b0;
        repeat (20) @(negedge clk);
        frame(8'h2B);

        repeat (200) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
